// File: rtl/mmio_pkg.sv
// mmio_pkg: register map offsets, STATUS/CTRL bit positions and default ID for mmio_responder
package mmio_pkg;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h4D49_5053;

    localparam logic [5:0] OFS_ID     = 6'h00;
    localparam logic [5:0] OFS_COUNT  = 6'h04;
    localparam logic [5:0] OFS_CMP    = 6'h08;
    localparam logic [5:0] OFS_STATUS = 6'h0C;
    localparam logic [5:0] OFS_TXDATA = 6'h10;
    localparam logic [5:0] OFS_CTRL   = 6'h14;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_MATCH   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-two circular byte queue with push/pop, full/empty, drop and occupancy
module byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_drop,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_data  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    // pointers and occupancy; pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // storage needs no reset: o_data is forced to zero while empty
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: windowed MMIO peripheral with cycle counter, compare interrupt and byte output FIFO
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ID_VALUE   = DEFAULT_ID_VALUE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        wr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_count;
    logic [31:0]   r_cmp;
    logic [1:0]    r_ctrl;
    logic          r_match;
    logic          r_ovf;
    logic [31:0]   r_rdata;
    logic          r_hit;
    logic          r_irq;
    logic          w_in_win;
    logic [5:0]    w_ofs;
    logic          w_wr;
    logic          w_match_now;
    logic          w_clr_match;
    logic          w_clr_ovf;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [CW-1:0] w_fifo_cnt;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_in_win    = Address[31:6] == BASE[31:6];
    assign w_ofs       = {Address[5:2], 2'b00};
    assign w_wr        = wr && w_in_win;
    assign w_match_now = r_ctrl[CTRL_CNT_EN] && r_count == r_cmp;
    assign w_clr_match = w_wr && w_ofs == OFS_STATUS && WriteData[ST_MATCH];
    assign w_clr_ovf   = w_wr && w_ofs == OFS_STATUS && WriteData[ST_OVF];
    assign w_unused    = &{1'b0, Address[1:0]};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_wr && w_ofs == OFS_TXDATA),
        .i_data  (WriteData[7:0]),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_fifo_cnt)
    );

    // read mux over the current (pre-edge) register state
    always_comb begin
        w_status = '0;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL] = w_full;
        w_status[ST_MATCH] = r_match;
        w_status[ST_OVF] = r_ovf;
        w_status[ST_CNT_LSB +: 3] = 3'(w_fifo_cnt);
        case (w_ofs)
            OFS_ID:     w_rdata = ID_VALUE;
            OFS_COUNT:  w_rdata = r_count;
            OFS_CMP:    w_rdata = r_cmp;
            OFS_STATUS: w_rdata = w_status;
            OFS_CTRL:   w_rdata = {30'b0, r_ctrl};
            default:    w_rdata = '0;
        endcase
    end

    // counter and RW registers; a COUNT write replaces that cycle's increment
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_cmp   <= '1;
            r_ctrl  <= '0;
        end else begin
            r_count <= (w_wr && w_ofs == OFS_COUNT) ? WriteData : r_count + 32'(r_ctrl[CTRL_CNT_EN]);
            r_cmp   <= (w_wr && w_ofs == OFS_CMP) ? WriteData : r_cmp;
            r_ctrl  <= (w_wr && w_ofs == OFS_CTRL) ? WriteData[1:0] : r_ctrl;
        end
    end

    // sticky flags: a new set event beats a simultaneous write-one-to-clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_match <= w_match_now || (r_match && !w_clr_match);
            r_ovf   <= w_drop || (r_ovf && !w_clr_ovf);
            r_irq   <= r_match && r_ctrl[CTRL_IRQ_EN];
        end
    end

    // one-cycle read port matching main-memory latency
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_rdata <= w_in_win ? w_rdata : '0;
            r_hit   <= w_in_win;
        end
    end

    assign ReadData  = r_rdata;
    assign hit       = r_hit;
    assign out_valid = !w_empty;
    assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed scoreboard bench for mmio_responder
module tb_mmio_responder;

    localparam logic [31:0] A_ID     = 32'h1000;
    localparam logic [31:0] A_COUNT  = 32'h1004;
    localparam logic [31:0] A_CMP    = 32'h1008;
    localparam logic [31:0] A_STATUS = 32'h100C;
    localparam logic [31:0] A_TX     = 32'h1010;
    localparam logic [31:0] A_CTRL   = 32'h1014;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic        wr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] rd_q[$];
    logic        hit_q[$];
    logic [7:0]  fifo_q[$];
    logic        m_ovf = 1'b0;

    mmio_responder dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (Address),
        .wr        (wr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        WriteData = d;
        wr = 1'b1;
        tick;
        wr = 1'b0;
        Address = '0;
        WriteData = '0;
    endtask

    task automatic push(input logic [7:0] b);
        if (fifo_q.size() < 4) fifo_q.push_back(b);
        else m_ovf = 1'b1;
        wr_reg(A_TX, {24'h0, b});
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        Address = a;
        wr = 1'b0;
        rd_q.push_back(exp);
        hit_q.push_back(a[31:6] == A_ID[31:6]);
        tick;
        chk({tag, ".hit"}, 32'(hit), 32'(hit_q.pop_front()));
        chk(tag, ReadData, rd_q.pop_front());
        Address = '0;
    endtask

    function automatic logic [31:0] st_exp(input logic m);
        return 32'({3'(fifo_q.size()), m_ovf, m, fifo_q.size() == 4, fifo_q.size() == 0});
    endfunction

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) begin
            chk("drain.valid", 32'(out_valid), 32'd1);
            chk("drain.data", 32'(out_data), 32'(fifo_q.pop_front()));
            tick;
        end
        out_ready = 1'b0;
        chk("drain.after_valid", 32'(out_valid), 32'(fifo_q.size() != 0));
    endtask

    initial begin
        reset = 1'b1;
        wr = 1'b0;
        Address = '0;
        WriteData = '0;
        out_ready = 1'b0;
        tick;
        tick;
        chk("rst.ReadData", ReadData, 32'h0);
        chk("rst.hit", 32'(hit), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.irq", 32'(irq), 32'h0);
        reset = 1'b0;

        rd(A_ID, 32'h4D49_5053, "id");
        rd(32'h0000_0800, 32'h0, "miss_low");
        rd(32'h0000_1040, 32'h0, "miss_high");
        rd(32'h0000_103C, 32'h0, "unmapped");
        rd(A_COUNT, 32'h0, "count_rst");
        rd(A_CMP, 32'hFFFF_FFFF, "cmp_rst");
        rd(A_CTRL, 32'h0, "ctrl_rst");
        rd(A_STATUS, st_exp(1'b0), "status_rst");

        wr_reg(A_CMP, 32'd10);
        wr_reg(A_CTRL, 32'd1);
        repeat (15) tick;
        rd(A_STATUS, st_exp(1'b1), "status_match");
        wr_reg(A_CTRL, 32'd3);
        chk("irq.delay", 32'(irq), 32'h0);
        tick;
        chk("irq.set", 32'(irq), 32'h1);
        wr_reg(A_STATUS, 32'd4);
        chk("irq.hold", 32'(irq), 32'h1);
        tick;
        chk("irq.drop", 32'(irq), 32'h0);
        rd(A_STATUS, st_exp(1'b0), "status_w1c");
        wr_reg(A_CTRL, 32'd0);

        push(8'h41);
        chk("fifo.first_valid", 32'(out_valid), 32'h1);
        chk("fifo.first_data", 32'(out_data), 32'h41);
        push(8'h42);
        push(8'h43);
        push(8'h44);
        push(8'h45);
        rd(A_STATUS, st_exp(1'b0), "status_full_ovf");
        rd(A_TX, 32'h0, "txdata_read");
        chk("fifo.stable", 32'(out_data), 32'(fifo_q[0]));
        drain(4);
        wr_reg(A_STATUS, 32'd8);
        m_ovf = 1'b0;
        rd(A_STATUS, st_exp(1'b0), "status_ovf_clr");

        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        out_ready = 1'b1;
        chk("fifo.full_head", 32'(out_data), 32'(fifo_q[0]));
        wr_reg(A_TX, 32'h55);
        void'(fifo_q.pop_front());
        fifo_q.push_back(8'h55);
        out_ready = 1'b0;
        rd(A_STATUS, st_exp(1'b0), "status_full_pushpop");
        drain(4);

        out_ready = 1'b1;
        wr_reg(A_TX, 32'h77);
        chk("fifo.empty_push_valid", 32'(out_valid), 32'h1);
        chk("fifo.empty_push_data", 32'(out_data), 32'h77);
        tick;
        chk("fifo.empty_after_pop", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        wr_reg(A_CTRL, 32'd1);
        wr_reg(A_COUNT, 32'hFFFF_FFFE);
        rd(A_COUNT, 32'hFFFF_FFFE, "wrap0");
        rd(A_COUNT, 32'hFFFF_FFFF, "wrap1");
        rd(A_COUNT, 32'h0, "wrap2");
        rd(A_COUNT, 32'h1, "wrap3");
        wr_reg(A_COUNT, 32'h100);
        rd(A_COUNT, 32'h100, "count_wr_wins");
        rd(A_COUNT, 32'h101, "count_after_wr");
        wr_reg(A_CMP, 32'h200);
        wr_reg(A_COUNT, 32'h200);
        wr_reg(A_STATUS, 32'd4);
        rd(A_STATUS, st_exp(1'b1), "match_set_wins");
        wr_reg(A_STATUS, 32'd4);
        rd(A_STATUS, st_exp(1'b0), "match_cleared");

        wr_reg(A_CTRL, 32'd3);
        push(8'h88);
        push(8'h99);
        chk("pre_rst.valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        out_ready = 1'b1;
        wr = 1'b1;
        Address = A_CTRL;
        WriteData = 32'd3;
        tick;
        reset = 1'b0;
        out_ready = 1'b0;
        wr = 1'b0;
        Address = '0;
        WriteData = '0;
        fifo_q.delete();
        m_ovf = 1'b0;
        chk("mid_rst.out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst.out_data", 32'(out_data), 32'h0);
        chk("mid_rst.ReadData", ReadData, 32'h0);
        chk("mid_rst.hit", 32'(hit), 32'h0);
        chk("mid_rst.irq", 32'(irq), 32'h0);
        rd(A_STATUS, st_exp(1'b0), "mid_rst.status");
        rd(A_COUNT, 32'h0, "mid_rst.count");
        rd(A_CTRL, 32'h0, "mid_rst.ctrl");
        rd(A_CMP, 32'hFFFF_FFFF, "mid_rst.cmp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
